// File: rtl/dg0045_display_drv.sv
// dg0045_display_drv: captures 4-bit digits from the CPU ND/nL strobe interface
// and drives a 4-digit multiplexed 7-segment display.
//
// Ports:
//   clk        - core clock, rising edge
//   rst        - asynchronous active-high reset
//   nd_n       - ND strobe, active low, >= 2 clk wide
//   nl_n[3:0]  - data nibble, active low, stable while nd_n is low
//   blank_lz   - leading-zero suppression enable (static)
//   seg_n[6:0] - segments {g,f,e,d,c,b,a}, active low
//   dig_n[3:0] - digit enables, active low
//   frame_done - one-cycle pulse when a 4-nibble frame is committed
//   slot_cnt   - nibbles captured in the current partial frame
module dg0045_display_drv #(
  parameter int unsigned REFRESH_DIV = 1024,
  parameter int unsigned BLANK_CYC   = 2,
  parameter int unsigned TIMEOUT     = 4096
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       nd_n,
  input  logic [3:0] nl_n,
  input  logic       blank_lz,
  output logic [6:0] seg_n,
  output logic [3:0] dig_n,
  output logic       frame_done,
  output logic [1:0] slot_cnt
);

  localparam logic [15:0] PrescMax    = 16'(REFRESH_DIV - 1);
  localparam logic [15:0] BlankCyc    = 16'(BLANK_CYC);
  localparam logic [15:0] TimeoutLast = 16'(TIMEOUT - 1);

  // Active-high 7-segment shapes, {g,f,e,d,c,b,a}.
  function automatic logic [6:0] hex7(input logic [3:0] v);
    logic [6:0] s;
    case (v)
      4'h0:    s = 7'h3F;
      4'h1:    s = 7'h06;
      4'h2:    s = 7'h5B;
      4'h3:    s = 7'h4F;
      4'h4:    s = 7'h66;
      4'h5:    s = 7'h6D;
      4'h6:    s = 7'h7D;
      4'h7:    s = 7'h07;
      4'h8:    s = 7'h7F;
      4'h9:    s = 7'h6F;
      4'hA:    s = 7'h77;
      4'hB:    s = 7'h7C;
      4'hC:    s = 7'h39;
      4'hD:    s = 7'h5E;
      4'hE:    s = 7'h79;
      default: s = 7'h71;
    endcase
    return s;
  endfunction

  // Synchronizers: strobe and data share the same depth so they stay aligned.
  logic       nd_s1_q, nd_s2_q, nd_prev_q;
  logic [3:0] nl_s1_q, nl_s2_q;
  // warm_q counts edges until nd_s2_q holds a real sample rather than its reset
  // value; armed_q then requires a genuine high before the first capture.
  logic [1:0] warm_q, warm_d;
  logic       armed_q, armed_d;

  logic [3:0][3:0] shadow_q, shadow_d;
  logic [3:0][3:0] display_q, display_d;
  logic [1:0]      slot_q, slot_d;
  logic [15:0]     idle_q, idle_d;
  logic            commit_q, commit_d;
  logic            frame_done_q;

  logic [15:0] presc_q, presc_d;
  logic [1:0]  idx_q, idx_d;
  logic [3:0]  dig_q, dig_d;
  logic [6:0]  seg_q, seg_d;
  // Forces a segment load on the first edge after reset, since that slot
  // starts without a prescaler wrap.
  logic        init_q;

  logic       cap;
  logic [3:0] nib;
  logic       hi_zero;
  logic       seg_load;

  always_comb begin
    cap     = armed_q & nd_prev_q & ~nd_s2_q;
    warm_d  = (warm_q == 2'd2) ? warm_q : warm_q + 2'd1;
    armed_d = armed_q | ((warm_q == 2'd2) & nd_s2_q);

    shadow_d = shadow_q;
    slot_d   = slot_q;
    idle_d   = 16'd0;
    commit_d = 1'b0;
    if (cap) begin
      shadow_d = {shadow_q[2:0], ~nl_s2_q};
      slot_d   = slot_q + 2'd1;
      commit_d = (slot_q == 2'd3);
    end else if (slot_q != 2'd0) begin
      if (idle_q == TimeoutLast) begin
        slot_d = 2'd0;
      end else begin
        idle_d = idle_q + 16'd1;
      end
    end

    display_d = commit_q ? shadow_q : display_q;

    if (presc_q == PrescMax) begin
      presc_d = 16'd0;
      idx_d   = idx_q + 2'd1;
    end else begin
      presc_d = presc_q + 16'd1;
      idx_d   = idx_q;
    end

    dig_d = (presc_d < BlankCyc) ? 4'hF : ~(4'b0001 << idx_d);

    // Segments latch only at slot start so a commit never changes a lit digit.
    nib = display_d[idx_d];
    case (idx_d)
      2'd3:    hi_zero = (display_d[3] == 4'd0);
      2'd2:    hi_zero = (display_d[3:2] == 8'd0);
      2'd1:    hi_zero = (display_d[3:1] == 12'd0);
      default: hi_zero = 1'b0;
    endcase
    seg_load = (presc_d == 16'd0) | init_q;
    seg_d    = seg_q;
    if (seg_load) begin
      seg_d = (blank_lz && hi_zero) ? 7'h7F : ~hex7(nib);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      nd_s1_q      <= 1'b1;
      nd_s2_q      <= 1'b1;
      nd_prev_q    <= 1'b1;
      nl_s1_q      <= 4'hF;
      nl_s2_q      <= 4'hF;
      warm_q       <= 2'd0;
      armed_q      <= 1'b0;
      shadow_q     <= '0;
      display_q    <= '0;
      slot_q       <= 2'd0;
      idle_q       <= 16'd0;
      commit_q     <= 1'b0;
      frame_done_q <= 1'b0;
      presc_q      <= 16'd0;
      idx_q        <= 2'd0;
      dig_q        <= 4'hF;
      seg_q        <= 7'h7F;
      init_q       <= 1'b1;
    end else begin
      nd_s1_q      <= nd_n;
      nd_s2_q      <= nd_s1_q;
      nd_prev_q    <= nd_s2_q;
      nl_s1_q      <= nl_n;
      nl_s2_q      <= nl_s1_q;
      warm_q       <= warm_d;
      armed_q      <= armed_d;
      shadow_q     <= shadow_d;
      display_q    <= display_d;
      slot_q       <= slot_d;
      idle_q       <= idle_d;
      commit_q     <= commit_d;
      frame_done_q <= commit_q;
      presc_q      <= presc_d;
      idx_q        <= idx_d;
      dig_q        <= dig_d;
      seg_q        <= seg_d;
      init_q       <= 1'b0;
    end
  end

  assign seg_n      = seg_q;
  assign dig_n      = dig_q;
  assign frame_done = frame_done_q;
  assign slot_cnt   = slot_q;

endmodule

// File: tb/tb_dg0045_display_drv.sv
module tb_dg0045_display_drv;

  localparam int R  = 8;
  localparam int B  = 2;
  localparam int TO = 64;

  logic       clk = 1'b0;
  logic       rst;
  logic       nd_n;
  logic [3:0] nl_n;
  logic       blank_lz;
  logic [6:0] seg_n;
  logic [3:0] dig_n;
  logic       frame_done;
  logic [1:0] slot_cnt;

  int checks = 0;
  int errors = 0;
  int ecnt;
  int last_cap;

  // Reference model: captured nibbles, frame count and committed display.
  logic [3:0] m_sh[4];
  logic [3:0] m_disp[4];
  int         m_cnt;

  logic [6:0] segtab[16] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                             7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};

  dg0045_display_drv #(
    .REFRESH_DIV(R),
    .BLANK_CYC  (B),
    .TIMEOUT    (TO)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .nd_n      (nd_n),
    .nl_n      (nl_n),
    .blank_lz  (blank_lz),
    .seg_n     (seg_n),
    .dig_n     (dig_n),
    .frame_done(frame_done),
    .slot_cnt  (slot_cnt)
  );

  always #5 clk = ~clk;

  // Rising edges since reset release; gives the scan position directly.
  always @(posedge clk or posedge rst) begin
    if (rst) ecnt <= 0;
    else     ecnt <= ecnt + 1;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  task automatic chk(input string tag, input logic [15:0] got, input logic [15:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 4; i++) begin
      m_sh[i]   = 4'd0;
      m_disp[i] = 4'd0;
    end
    m_cnt = 0;
  endtask

  // One strobe; capture expected at edge k+2 where k is the first edge seeing nd_n low.
  task automatic strobe(input logic [3:0] nib, input int low, input int gap);
    int  old_cnt, new_cnt, total;
    bit  wrap;
    old_cnt = m_cnt;
    m_sh[3] = m_sh[2];
    m_sh[2] = m_sh[1];
    m_sh[1] = m_sh[0];
    m_sh[0] = nib;
    m_cnt   = (m_cnt + 1) % 4;
    new_cnt = m_cnt;
    wrap    = (m_cnt == 0);
    if (wrap) for (int i = 0; i < 4; i++) m_disp[i] = m_sh[i];
    nd_n  = 1'b0;
    nl_n  = ~nib;
    total = ((low > 3) ? low : 3) + gap;
    for (int n = 1; n <= total; n++) begin
      @(negedge clk);
      if (n == 2) chk("slot_before_capture", 16'(slot_cnt), 16'(old_cnt));
      if (n == 3) begin
        chk("slot_at_capture", 16'(slot_cnt), 16'(new_cnt));
        chk("frame_done_early", 16'(frame_done), 16'd0);
        last_cap = ecnt;
      end
      if (n == 4) chk("frame_done_pulse", 16'(frame_done), 16'(wrap));
      if (n == 5) chk("frame_done_width", 16'(frame_done), 16'd0);
      if (n == total) chk("slot_single_capture", 16'(slot_cnt), 16'(new_cnt));
      if (n == low) begin
        nd_n = 1'b1;
        nl_n = 4'($urandom);
      end
    end
  endtask

  // Checks one full scan frame (4 slots) against the model display.
  task automatic scan_check();
    int         p, i;
    logic [15:0] v;
    logic [6:0] es;
    logic [3:0] ed;
    v = {m_disp[3], m_disp[2], m_disp[1], m_disp[0]};
    for (int c = 0; c < 4 * R; c++) begin
      @(negedge clk);
      p  = ecnt % R;
      i  = (ecnt / R) % 4;
      ed = (p < B) ? 4'hF : ~(4'b0001 << i);
      chk("dig_n", 16'(dig_n), 16'(ed));
      if (blank_lz && i > 0 && (v >> (4 * i)) == 16'd0) es = 7'h7F;
      else es = ~segtab[m_disp[i]];
      chk("seg_n", 16'(seg_n), 16'(es));
    end
  endtask

  task automatic settle_and_scan();
    repeat (R + 1) @(negedge clk);
    scan_check();
  endtask

  task automatic reset_outputs_check();
    chk("rst_seg_n", 16'(seg_n), 16'h7F);
    chk("rst_dig_n", 16'(dig_n), 16'hF);
    chk("rst_frame_done", 16'(frame_done), 16'd0);
    chk("rst_slot_cnt", 16'(slot_cnt), 16'd0);
  endtask

  initial begin
    rst      = 1'b1;
    nd_n     = 1'b1;
    nl_n     = 4'hF;
    blank_lz = 1'b0;
    model_reset();
    repeat (3) @(negedge clk);
    reset_outputs_check();
    rst = 1'b0;
    repeat (4) @(negedge clk);

    // Directed frame 1,2,3,4 with a long strobe in the middle.
    strobe(4'd1, 2, 3);
    strobe(4'd2, 2, 3);
    strobe(4'd3, 6, 3);
    strobe(4'd4, 2, 4);
    settle_and_scan();

    // Random frames, zero-biased nibbles to exercise suppression.
    for (int f = 0; f < 6; f++) begin
      blank_lz = 1'($urandom);
      for (int s = 0; s < 4; s++) begin
        strobe(($urandom % 3 == 0) ? 4'd0 : 4'($urandom),
               int'($urandom_range(2, 6)), int'($urandom_range(2, 6)));
      end
      settle_and_scan();
    end

    // Leading-zero suppression on 0,0,5,0.
    strobe(4'd0, 2, 2);
    strobe(4'd0, 2, 2);
    strobe(4'd5, 2, 2);
    strobe(4'd0, 2, 2);
    blank_lz = 1'b1;
    settle_and_scan();
    blank_lz = 1'b0;
    settle_and_scan();

    // Timeout of a partial frame, then a clean frame.
    strobe(4'hA, 2, 2);
    strobe(4'hB, 2, 2);
    while (ecnt < last_cap + TO - 1) @(negedge clk);
    chk("slot_before_timeout", 16'(slot_cnt), 16'd2);
    @(negedge clk);
    chk("slot_after_timeout", 16'(slot_cnt), 16'd0);
    m_cnt = 0;
    scan_check();
    strobe(4'h9, 2, 2);
    strobe(4'h8, 3, 2);
    strobe(4'h7, 2, 2);
    strobe(4'hC, 2, 2);
    settle_and_scan();

    // Reset mid-frame, with nd_n already low when reset is released.
    strobe(4'h3, 2, 2);
    strobe(4'h4, 2, 2);
    strobe(4'h5, 2, 2);
    rst = 1'b1;
    #2;
    reset_outputs_check();
    model_reset();
    nd_n = 1'b0;
    nl_n = 4'h0;
    repeat (2) @(negedge clk);
    reset_outputs_check();
    rst = 1'b0;
    for (int n = 0; n < 8; n++) begin
      @(negedge clk);
      chk("no_capture_mid_strobe", 16'(slot_cnt), 16'd0);
    end
    nd_n = 1'b1;
    repeat (4) @(negedge clk);
    strobe(4'h6, 2, 3);
    blank_lz = 1'b1;
    settle_and_scan();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/dg0045_display_drv.md
DG0045_DISPLAY_DRV -- requirements
Module: dg0045_display_drv

Interface
REQ-001 Parameter REFRESH_DIV, default 1024: clock cycles per scanned digit; legal range 8..65535.
REQ-002 Parameter BLANK_CYC, default 2: inter-digit blanking cycles at the start of each digit slot; legal range 0..REFRESH_DIV-1.
REQ-003 Parameter TIMEOUT, default 4096: idle cycles after which a partial frame is abandoned; legal range 16..65535.
REQ-004 Port clk, input, 1: single clock, rising edge, same clock that drives the CPU core.
REQ-005 Port rst, input, 1: reset, asynchronous and active-high.
REQ-006 Port nd_n, input, 1: CPU ND strobe, active low, at least 2 clk wide.
REQ-007 Port nl_n, input, 4: CPU nL data nibble, active low, stable while nd_n is low.
REQ-008 Port blank_lz, input, 1: leading-zero suppression enable, static.
REQ-009 Port seg_n, output, 7: segments {g,f,e,d,c,b,a}, active low.
REQ-010 Port dig_n, output, 4: digit enables, active low, one-hot or all high.
REQ-011 Port frame_done, output, 1: one-cycle pulse when a full frame has been committed.
REQ-012 Port slot_cnt, output, 2: number of nibbles captured in the current partial frame.

Function
REQ-013 The block SHALL synchronize nd_n and nl_n through identical 2-flop stages, so that data and strobe stay aligned.
REQ-014 Capture SHALL occur on the synchronized falling edge of nd_n: if edge k is the first edge that samples nd_n low, capture happens at edge k+2, and exactly one capture occurs per low pulse.
REQ-015 On capture, shadow[0] SHALL load ~nl_n, shadow[i] SHALL load shadow[i-1] for i=1..3, and slot_cnt SHALL increment.
REQ-016 On the capture that brings slot_cnt from 3 to 0 (wrap), the display register SHALL load the full shadow contents one edge later, and frame_done SHALL pulse high for that same single cycle.
REQ-017 After commit, display digit 3 SHALL hold the first nibble of the frame and digit 0 the last.
REQ-018 An idle counter SHALL clear on every capture and count otherwise while slot_cnt is non-zero; on reaching TIMEOUT, slot_cnt SHALL clear to 0.
  - Shadow contents are retained on timeout.
  - The display register does not change on timeout.
REQ-019 If a capture and timeout expiry coincide, the capture SHALL win: slot_cnt increments and the idle counter clears.
REQ-020 The refresh prescaler SHALL count 0..REFRESH_DIV-1 and wrap; at wrap, digit index 0..3 increments mod 4.
REQ-021 dig_n SHALL drive all ones while the prescaler is below BLANK_CYC; otherwise it drives the low bit at the current index only.
REQ-022 seg_n SHALL carry the registered hex decode (0-F, standard 7-segment shapes) of the indexed display nibble, updated at the same edge as dig_n, so that no glitch occurs within a slot.
REQ-023 With blank_lz=1, digit i (i=3..1) SHALL be blanked (seg_n=7'h7F) when it and every higher digit are zero; digit 0 SHALL never be blanked.
REQ-024 A commit during a digit slot SHALL take effect at the next slot boundary only.

Reset
REQ-025 While rst is high, every register SHALL clear: sync flops to idle (1), shadow, display, slot_cnt, idle counter, prescaler and digit index to 0.
REQ-026 While rst is high, the outputs SHALL hold seg_n=7'h7F, dig_n=4'hF, frame_done=0 and slot_cnt=0.
REQ-027 Reset deassertion mid-strobe (nd_n already low) SHALL NOT produce a capture until nd_n has been seen high and then low again.

Verification
REQ-028 Frame commit: 4 strobes with nl_n=~1,~2,~3,~4 -> frame_done pulse 1 cycle after the 4th capture; display = 1,2,3,4 (digit3..0); slot_cnt 1,2,3,0.
REQ-029 Capture latency: nd_n low for 2 cycles -> exactly one capture, at edge k+2; a 6-cycle low pulse -> still one capture.
REQ-030 Timeout: 2 strobes, then idle for TIMEOUT cycles -> slot_cnt=0 and display unchanged; the next 4 strobes commit cleanly.
REQ-031 Scan and blanking: REFRESH_DIV=8, BLANK_CYC=2 -> dig_n sequence F,F,E x6, F,F,D x6, ...; seg_n matches the indexed nibble.
REQ-032 Leading-zero suppression: display 0,0,5,0 with blank_lz=1 -> digits 3 and 2 blank, digit 1 shows 5, digit 0 shows 0; with blank_lz=0 -> all four digits shown.
REQ-033 Reset mid-frame: assert rst after 3 captures -> all outputs at their reset values; following the reset, a strobe sequence yields slot_cnt=1 after the first capture.
